// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for the multi-cycle ALU.
// The master drives operands and out_ready; the slave (ALU) drives the result side.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] read_data_1;
    logic [WIDTH-1:0] read_data_2;
    logic [SHW-1:0]   shamt;
    logic [3:0]       control;
    logic             select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       zeros;

    modport master (
        output in_valid, read_data_1, read_data_2, shamt, control, select, out_ready,
        input  in_ready, out_valid, alu_res, zeros
    );

    modport slave (
        input  in_valid, read_data_1, read_data_2, shamt, control, select, out_ready,
        output in_ready, out_valid, alu_res, zeros
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply,
// valid/ready handshakes on both sides with a result held until taken.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input logic      clk,
    input logic      rst,
    alu_mc_if.slave  bus
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_DIFF = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_nx;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       zeros_q;

    logic             accept_c;
    logic             mul_last_c;
    logic [SHW-1:0]   amt_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;

    assign accept_c   = bus.in_valid && in_ready_q;
    assign mul_last_c = (cnt_q == SHW'(WIDTH - 1));
    assign prod_nx    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the last multiply iteration and the DONE entry share one edge
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_nx = (bus.control == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_last_c) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nx == S_IDLE);
            out_valid_q <= (state_nx == S_DONE);
        end
    end

    // Single-cycle datapath, evaluated on the operands presented at acceptance
    always_comb begin
        amt_c   = bus.select ? bus.shamt : bus.read_data_2[SHW-1:0];
        sum_c   = {1'b0, bus.read_data_1} + {1'b0, bus.read_data_2};
        res_c   = '0;
        carry_c = 1'b0;
        case (bus.control)
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
            end
            OP_COMP: res_c = ~bus.read_data_2 + WIDTH'(1);
            OP_AND:  res_c = bus.read_data_1 & bus.read_data_2;
            OP_XOR:  res_c = bus.read_data_1 ^ bus.read_data_2;
            OP_DIFF: res_c = (bus.read_data_1 >= bus.read_data_2) ?
                             (bus.read_data_1 - bus.read_data_2) :
                             (bus.read_data_2 - bus.read_data_1);
            OP_SLL:  res_c = bus.read_data_1 << amt_c;
            OP_SRL:  res_c = bus.read_data_1 >> amt_c;
            OP_SRA:  res_c = $unsigned($signed(bus.read_data_1) >>> amt_c);
            default: res_c = '0;
        endcase
    end

    // Operand latch, shift-add multiplier and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            zeros_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q      <= bus.read_data_1;
                        mplier_q <= bus.read_data_2;
                        mcand_q  <= PW'(bus.read_data_1);
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        if (bus.control != OP_MUL) begin
                            res_q   <= res_c;
                            zeros_q <= {carry_c, bus.read_data_1[WIDTH-1],
                                        (bus.read_data_1 == '0)};
                        end
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (mul_last_c) begin
                        res_q   <= prod_nx[WIDTH-1:0];
                        zeros_q <= {(prod_nx[PW-1:WIDTH] != '0), a_q[WIDTH-1], (a_q == '0)};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_res   = res_q;
    assign bus.zeros     = zeros_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance, a latency/result model checked every
// cycle, and directed vectors with literal expected values.
module tb_alu_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32), .SHW(5)) b32 ();
    alu_mc_if #(.WIDTH(8),  .SHW(3)) b8 ();

    alu_mc #(.WIDTH(32), .SHW(5)) u32 (.clk(clk), .rst(rst), .bus(b32));
    alu_mc #(.WIDTH(8),  .SHW(3)) u8  (.clk(clk), .rst(rst), .bus(b8));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Width-neutral views of both instances
    logic [63:0] o_res [2];
    logic [2:0]  o_z   [2];
    logic        o_valid [2];
    logic        o_ready [2];
    logic        i_valid [2];
    logic        i_ordy  [2];
    logic        i_sel   [2];
    logic [3:0]  i_op    [2];
    logic [63:0] i_a [2];
    logic [63:0] i_b [2];
    logic [63:0] i_sh [2];

    assign o_res[0] = 64'(b32.alu_res);   assign o_res[1] = 64'(b8.alu_res);
    assign o_z[0]   = b32.zeros;          assign o_z[1]   = b8.zeros;
    assign o_valid[0] = b32.out_valid;    assign o_valid[1] = b8.out_valid;
    assign o_ready[0] = b32.in_ready;     assign o_ready[1] = b8.in_ready;
    assign i_valid[0] = b32.in_valid;     assign i_valid[1] = b8.in_valid;
    assign i_ordy[0]  = b32.out_ready;    assign i_ordy[1]  = b8.out_ready;
    assign i_sel[0]   = b32.select;       assign i_sel[1]   = b8.select;
    assign i_op[0]    = b32.control;      assign i_op[1]    = b8.control;
    assign i_a[0]  = 64'(b32.read_data_1); assign i_a[1]  = 64'(b8.read_data_1);
    assign i_b[0]  = 64'(b32.read_data_2); assign i_b[1]  = 64'(b8.read_data_2);
    assign i_sh[0] = 64'(b32.shamt);       assign i_sh[1] = 64'(b8.shamt);

    int w_of [2] = '{32, 8};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Result of one operation from the arithmetic definition, for width w (w <= 32)
    function automatic void model_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] amt_raw, input int w,
                                     output logic [63:0] r, output logic [2:0] z);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] amt  = amt_raw % 64'(w);
        logic [63:0] t;
        logic        c = 1'b0;
        case (op)
            4'd0: begin t = a + b; r = t & mask; c = t[w]; end
            4'd1: r = (64'd0 - b) & mask;
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: r = (a > b) ? a - b : b - a;
            4'd5: r = (a << amt) & mask;
            4'd6: r = a >> amt;
            4'd7: begin
                r = a >> amt;
                if (a[w-1]) r = r | (mask & ~(mask >> amt));
            end
            4'd8: begin t = a * b; r = t & mask; c = ((t >> w) != 64'd0); end
            default: r = 64'd0;
        endcase
        z = {c, a[w-1], (a == 64'd0)};
    endfunction

    // Behavioural model: phase 0 idle, 1 multiplying, 2 result offered
    int          m_phase [2];
    int          m_left  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [63:0] m_res   [2];
    logic [2:0]  m_z     [2];
    logic [63:0] m_pres  [2];
    logic [2:0]  m_pz    [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_phase[d] = 0; m_valid[d] = 1'b0; m_ready[d] = 1'b1;
                m_res[d] = 64'd0; m_z[d] = 3'b000;
            end else begin
                case (m_phase[d])
                    0: if (i_valid[d]) begin
                        model_op(i_op[d], i_a[d], i_b[d], i_sel[d] ? i_sh[d] : i_b[d], w_of[d],
                                 m_pres[d], m_pz[d]);
                        m_ready[d] = 1'b0;
                        if (i_op[d] == 4'd8) begin
                            m_phase[d] = 1; m_left[d] = w_of[d];
                        end else begin
                            m_phase[d] = 2; m_valid[d] = 1'b1;
                            m_res[d] = m_pres[d]; m_z[d] = m_pz[d];
                        end
                    end
                    1: begin
                        m_left[d]--;
                        if (m_left[d] == 0) begin
                            m_phase[d] = 2; m_valid[d] = 1'b1;
                            m_res[d] = m_pres[d]; m_z[d] = m_pz[d];
                        end
                    end
                    default: if (i_ordy[d]) begin
                        m_phase[d] = 0; m_valid[d] = 1'b0; m_ready[d] = 1'b1;
                    end
                endcase
            end
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cyc%0d_out_valid", d), 64'(o_valid[d]), 64'(m_valid[d]));
                check($sformatf("cyc%0d_in_ready", d),  64'(o_ready[d]), 64'(m_ready[d]));
                check($sformatf("cyc%0d_alu_res", d),   o_res[d], m_res[d]);
                check($sformatf("cyc%0d_zeros", d),     64'(o_z[d]), 64'(m_z[d]));
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] sh, input logic sel);
        if (d == 0) begin
            b32.in_valid = v; b32.control = op; b32.read_data_1 = a[31:0];
            b32.read_data_2 = b[31:0]; b32.shamt = sh[4:0]; b32.select = sel;
        end else begin
            b8.in_valid = v; b8.control = op; b8.read_data_1 = a[7:0];
            b8.read_data_2 = b[7:0]; b8.shamt = sh[2:0]; b8.select = sel;
        end
    endtask

    task automatic set_ordy(input int d, input logic v);
        if (d == 0) b32.out_ready = v; else b8.out_ready = v;
    endtask

    // Issue one op and return the number of edges from acceptance to out_valid (inclusive)
    task automatic run_op(input int d, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] sh, input logic sel, output int lat);
        @(negedge clk);
        drive(d, 1'b1, op, a, b, sh, sel);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive(d, 1'b0, op, a, b, sh, sel);
        while (!o_valid[d] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_res(input int d);
        set_ordy(d, 1'b1);
        @(negedge clk);
        set_ordy(d, 1'b0);
    endtask

    task automatic op_check(input string name, input int d, input logic [3:0] op,
                            input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh,
                            input logic sel, input logic [63:0] er, input logic [2:0] ez, input int elat);
        int lat;
        run_op(d, op, a, b, sh, sel, lat);
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_res"}, o_res[d], er);
        check({name, "_zeros"}, 64'(o_z[d]), 64'(ez));
        release_res(d);
    endtask

    initial begin
        int lat;
        drive(0, 1'b0, 4'd0, 64'd0, 64'd0, 6'd0, 1'b0);
        drive(1, 1'b0, 4'd0, 64'd0, 64'd0, 6'd0, 1'b0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset_in_ready", 64'(o_ready[0]), 64'd1);
        check("reset_out_valid", 64'(o_valid[0]), 64'd0);
        check("reset_alu_res", o_res[0], 64'd0);
        check("reset_zeros", 64'(o_z[0]), 64'd0);

        op_check("add_carry", 0, 4'd0, 64'hFFFF_FFFF, 64'h1, 6'd0, 1'b0, 64'h0, 3'b110, 1);
        op_check("mul_ovf",   0, 4'd8, 64'h0001_0000, 64'h0001_0000, 6'd0, 1'b0, 64'h0, 3'b100, 33);
        op_check("mul_small", 0, 4'd8, 64'h7, 64'h6, 6'd0, 1'b0, 64'h2A, 3'b000, 33);
        op_check("sra_shamt", 0, 4'd7, 64'h8000_0000, 64'h0, 6'd4, 1'b1, 64'hF800_0000, 3'b010, 1);
        op_check("sra_regb",  0, 4'd7, 64'h8000_0000, 64'h24, 6'd0, 1'b0, 64'hF800_0000, 3'b010, 1);
        op_check("comp_zero", 0, 4'd1, 64'h0, 64'h0, 6'd0, 1'b0, 64'h0, 3'b001, 1);
        op_check("comp_min",  0, 4'd1, 64'h1, 64'h8000_0000, 6'd0, 1'b0, 64'h8000_0000, 3'b000, 1);
        op_check("comp_one",  0, 4'd1, 64'h1, 64'h1, 6'd0, 1'b0, 64'hFFFF_FFFF, 3'b000, 1);
        op_check("illegal",   0, 4'd11, 64'h0, 64'h5, 6'd0, 1'b0, 64'h0, 3'b001, 1);
        op_check("sll_zero",  0, 4'd5, 64'h1234_5678, 64'h0, 6'd0, 1'b1, 64'h1234_5678, 3'b000, 1);
        op_check("srl",       0, 4'd6, 64'hF000_0000, 64'h0, 6'd31, 1'b1, 64'h1, 3'b010, 1);
        op_check("and",       0, 4'd2, 64'hF0F0_F0F0, 64'hFF00_FF00, 6'd0, 1'b0, 64'hF000_F000, 3'b010, 1);
        op_check("xor",       0, 4'd3, 64'h0000_00FF, 64'h0000_0F0F, 6'd0, 1'b0, 64'h0000_0FF0, 3'b000, 1);

        // Backpressure: result holds, new requests are ignored while it waits
        run_op(0, 4'd4, 64'h5, 64'h9, 6'd0, 1'b0, lat);
        check("diff_lat", 64'(lat), 64'd1);
        drive(0, 1'b1, 4'd0, 64'h1, 64'h1, 6'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res", o_res[0], 64'h4);
            check("bp_in_ready", 64'(o_ready[0]), 64'd0);
            check("bp_out_valid", 64'(o_valid[0]), 64'd1);
        end
        drive(0, 1'b0, 4'd0, 64'h0, 64'h0, 6'd0, 1'b0);
        set_ordy(0, 1'b1);
        @(negedge clk);
        set_ordy(0, 1'b0);
        check("bp_done_valid", 64'(o_valid[0]), 64'd0);
        check("bp_done_ready", 64'(o_ready[0]), 64'd1);

        // Reset ten cycles into a multiply
        @(negedge clk);
        drive(0, 1'b1, 4'd8, 64'h3, 64'h5, 6'd0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 4'd8, 64'h3, 64'h5, 6'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmul_valid", 64'(o_valid[0]), 64'd0);
        check("rstmul_ready", 64'(o_ready[0]), 64'd1);
        check("rstmul_res", o_res[0], 64'd0);

        // A request presented during reset is not taken
        drive(0, 1'b1, 4'd0, 64'h1, 64'h1, 6'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 4'd0, 64'h0, 64'h0, 6'd0, 1'b0);
        @(negedge clk);
        check("rst_inval_valid", 64'(o_valid[0]), 64'd0);
        check("rst_inval_ready", 64'(o_ready[0]), 64'd1);
        op_check("add_after_rst", 0, 4'd0, 64'h2, 64'h3, 6'd0, 1'b0, 64'h5, 3'b000, 1);

        // Narrow instance
        op_check("w8_sll", 1, 4'd5, 64'h81, 64'h0, 6'd1, 1'b1, 64'h02, 3'b010, 1);
        op_check("w8_mul", 1, 4'd8, 64'h10, 64'h10, 6'd0, 1'b0, 64'h00, 3'b100, 9);
        op_check("w8_sra", 1, 4'd7, 64'h90, 64'h0B, 6'd0, 1'b0, 64'hF2, 3'b010, 1);
        op_check("w8_add", 1, 4'd0, 64'hF0, 64'h20, 6'd0, 1'b0, 64'h10, 3'b110, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
